fir_mac_seq: RTL
================

FIR_MAC_SEQ -- requirements
Module: fir_mac_seq

Interface
REQ-001 Parameters SHALL be as follows.
- N, 16, sample/coefficient width (signed Q4.11).
- TAPS, 8, filter length (power of 2, ≥2).

REQ-002 Ports SHALL be as follows.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  log2(TAPS)  coefficient index.
- coef_data  in  N  coefficient value, Q4.11.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  N  input sample, Q4.11.
- alu_a  out  N  multiplier operand to the ALU (sample).
- alu_b  out  N  multiplier operand to the ALU (coefficient).
- alu_sel  out  1  ALU op select: 0 add, 1 multiply.
- alu_out  in  32  combinational ALU result; multiply result is Q8.22.
- out_valid  out  1  filtered output valid.
- out_ready  in  1  downstream accepts output.
- out_data  out  N  filtered output, Q4.11.
- busy  out  1  high in any state other than IDLE.

REQ-003 Reset SHALL be asynchronous and active-low on rst_n, with a single clock clk.

Function
REQ-004 FSM states SHALL be IDLE, MAC, OUT; in_ready SHALL be 1 exactly in IDLE.
REQ-005 IDLE: on in_valid&&in_ready, the delay line SHALL shift (x[k]<=x[k-1], x[0]<=in_data), acc<=0, tap<=0, and the FSM SHALL go to MAC.
REQ-006 MAC: alu_sel=1, alu_a=x[tap], alu_b=coef[tap]; each cycle, acc<=acc+sign-extended alu_out and tap<=tap+1; after tap==TAPS-1 is accumulated, the FSM SHALL go to OUT.
REQ-007 The accumulator SHALL be 32+log2(TAPS) bits signed, so it cannot overflow.
REQ-008 Output conversion SHALL be y=(acc+2^10)>>>11 (round half up), saturated to [0x8000,0x7FFF]; it SHALL be registered into out_data on the MAC->OUT transition.
REQ-009 OUT: out_valid=1; out_data SHALL be stable until out_valid&&out_ready, then the FSM SHALL go to IDLE with out_valid=0 on the next cycle.
REQ-010 Latency: a sample accepted at edge 0 SHALL produce out_valid high after edge TAPS+1 (edge 9 with defaults); throughput is one sample per TAPS+2 cycles when out_ready=1.
REQ-011 Outside MAC, alu_sel, alu_a and alu_b SHALL be 0.
REQ-012 coef_we SHALL write coef[coef_addr] only in IDLE; writes in MAC or OUT SHALL be ignored.
REQ-013 Simultaneous coef_we and sample accept in IDLE: both SHALL take effect, and the new coefficient SHALL be used for that sample.
REQ-014 in_valid outside IDLE SHALL be ignored; no sample is lost, because in_ready=0.
REQ-015 busy SHALL equal (state!=IDLE).

Reset
REQ-016 While rst_n=0 the block SHALL hold: state=IDLE, delay line=0, coefficients=0, acc=0, tap=0, out_valid=0, out_data=0, alu_*=0, busy=0; in_ready SHALL be 1 after release.
REQ-017 Reset asserted mid-MAC or mid-OUT SHALL abort immediately; no out_valid SHALL follow for the aborted sample.

Verification
REQ-018 Impulse: coef[k]=(k+1)*0x0800, input 0x0800 then seven 0x0000 -> outputs 0x0800,0x1000,0x1800,...,0x4000.
REQ-019 Saturation: all coef=0x7FFF with eight inputs 0x7FFF -> final out 0x7FFF; all coef=0x7FFF with inputs 0x8000 -> out 0x8000.
REQ-020 Rounding: coef[0]=0x0001, others 0, x=0x0400 -> out 0x0001; x=0x03FF -> out 0x0000; x=0xFC00 -> out 0x0000.
REQ-021 Backpressure: out_ready=0 for 5 cycles in OUT -> out_valid and out_data stable, in_ready=0, a concurrent in_valid is not accepted, and the sample count is unchanged.
REQ-022 Latency/handshake: accept at edge 0 with out_ready=1 -> out_valid high for exactly one cycle after edge 9, and in_ready=1 again after edge 10.
REQ-023 Reset mid-MAC: rst_n low during MAC cycle 4 -> out_valid stays 0, coefficients read back as 0, and the next impulse yields an all-zero output.

Source files
------------

// File: rtl/fir_mac_seq.sv
// fir_mac_seq: sequential TAPS-tap FIR filter. It runs one multiply-accumulate per
// cycle through an external combinational ALU and has valid/ready handshakes on its
// input and output.
module fir_mac_seq #(
    parameter  int unsigned N    = 16,
    parameter  int unsigned TAPS = 8,
    localparam int unsigned AW   = $clog2(TAPS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          coef_we,
    input  logic [AW-1:0] coef_addr,
    input  logic [N-1:0]  coef_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    output logic [N-1:0]  alu_a,
    output logic [N-1:0]  alu_b,
    output logic          alu_sel,
    input  logic [31:0]   alu_out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    output logic          busy
);

    localparam int unsigned ALU_W = 32;
    localparam int unsigned TW    = AW + 1;
    localparam int unsigned ACC_W = ALU_W + AW;
    localparam int unsigned FRAC  = 11;
    localparam logic signed [ACC_W-1:0] ROUND_K = ACC_W'(2 ** (FRAC - 1));

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                   r_state;
    logic [N-1:0]             r_x    [TAPS];
    logic [N-1:0]             r_coef [TAPS];
    logic signed [ACC_W-1:0]  r_acc;
    logic [TW-1:0]            r_tap;
    logic [N-1:0]             r_alu_a;
    logic [N-1:0]             r_alu_b;
    logic                     r_alu_sel;
    logic                     r_out_valid;
    logic [N-1:0]             r_out_data;
    logic                     r_in_ready;
    logic                     r_busy;

    logic                     w_accept;
    logic                     w_coef_wr;
    logic [N-1:0]             w_coef0;
    logic [AW-1:0]            w_idx_nxt;
    logic signed [ACC_W-1:0]  w_alu_ext;

    // Round half up from Q(.22) to Q4.11, then saturate to the N-bit signed range.
    function automatic logic [N-1:0] f_round_sat(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] sum;
        logic signed [ACC_W-1:0] q;
        logic [ACC_W-N:0]        hi;
        sum = acc + ROUND_K;
        q   = sum >>> FRAC;
        hi  = q[ACC_W-1:N-1];
        if ((&hi) || !(|hi)) begin
            return q[N-1:0];
        end else if (q[ACC_W-1]) begin
            return {1'b1, {(N-1){1'b0}}};
        end else begin
            return {1'b0, {(N-1){1'b1}}};
        end
    endfunction

    // Handshake and bookkeeping decodes.
    assign w_accept  = in_valid && (r_state == S_IDLE);
    assign w_coef_wr = coef_we && (r_state == S_IDLE);
    // A coefficient written together with the accepted sample is used for that sample.
    assign w_coef0   = (w_coef_wr && (coef_addr == '0)) ? coef_data : r_coef[0];
    assign w_idx_nxt = r_tap[AW-1:0] + AW'(1);
    assign w_alu_ext = {{AW{alu_out[ALU_W-1]}}, alu_out};

    // Sample delay line, shifted once per accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) begin
                r_x[k] <= '0;
            end
        end else if (w_accept) begin
            r_x[0] <= in_data;
            for (int k = 1; k < TAPS; k++) begin
                r_x[k] <= r_x[k-1];
            end
        end
    end

    // Coefficient store, writable only while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) begin
                r_coef[k] <= '0;
            end
        end else if (w_coef_wr) begin
            r_coef[coef_addr] <= coef_data;
        end
    end

    // Control FSM with registered ALU operands, output data and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_tap       <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_sel   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state    <= S_MAC;
                        r_acc      <= '0;
                        r_tap      <= '0;
                        r_alu_sel  <= 1'b1;
                        r_alu_a    <= in_data;
                        r_alu_b    <= w_coef0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                S_MAC: begin
                    if (r_tap == TW'(TAPS)) begin
                        // All taps are summed, so convert the total and present it.
                        r_state     <= S_OUT;
                        r_out_data  <= f_round_sat(r_acc);
                        r_out_valid <= 1'b1;
                        r_alu_sel   <= 1'b0;
                        r_alu_a     <= '0;
                        r_alu_b     <= '0;
                    end else begin
                        r_acc <= r_acc + w_alu_ext;
                        r_tap <= r_tap + TW'(1);
                        if (r_tap == TW'(TAPS - 1)) begin
                            r_alu_a <= '0;
                            r_alu_b <= '0;
                        end else begin
                            r_alu_a <= r_x[w_idx_nxt];
                            r_alu_b <= r_coef[w_idx_nxt];
                        end
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_alu_sel   <= 1'b0;
                    r_alu_a     <= '0;
                    r_alu_b     <= '0;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_sel   = r_alu_sel;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule
